comparator_nbit_seq: RTL

Parametrised, multi-cycle magnitude comparator. It is the successor to the fixed 2-bit structural comparator.
- Compares two WIDTH-bit operands MSB-first, DIGIT bits per clock.
- Supports unsigned and two's-complement modes.
- Uses valid/ready handshakes on input and output.
- Sits between operand producers (ALU and sort datapaths) and consumers that need one-hot greater/equal/less flags.

---
 rtl/comparator_nbit_seq.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/comparator_nbit_seq.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, unsigned or two's-complement.
// Optional early termination on the first unequal slice: define CMP_EARLY_EXIT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | in_ready high, waiting for in_valid to capture operands
// S_COMPARE | one DIGIT-wide slice compared per edge, MSB slice first
// S_DONE    | out_valid high with one-hot flags, held until out_ready
module comparator_nbit_seq #(
   parameter  int WIDTH = 8,
   parameter  int DIGIT = 2,
   localparam int NDIG  = WIDTH / DIGIT,
   localparam int CW    = $clog2(NDIG) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             signed_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             A_greater_B,
   output logic             A_equals_B,
   output logic             A_less_B,
   output logic [CW-1:0]    cycles
);

   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

   if (WIDTH < 2) begin : g_width_chk
      $error("comparator_nbit_seq: WIDTH must be at least 2");
   end
   if (WIDTH % DIGIT != 0) begin : g_digit_chk
      $error("comparator_nbit_seq: WIDTH must be a multiple of DIGIT");
   end

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPARE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [IW-1:0]    idx_q;
   logic             gt_s_q;
   logic             lt_s_q;
   logic [CW-1:0]    cyc_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             gt_q;
   logic             eq_q;
   logic             lt_q;

   logic [DIGIT-1:0] da;
   logic [DIGIT-1:0] db;
   logic             decided;
   logic             gt_d;
   logic             lt_d;
   logic             last_d;
   logic             exit_d;

   // Operands shift left each cycle, so the slice under test is always the top DIGIT bits.
   assign da = a_q[WIDTH-1 -: DIGIT];
   assign db = b_q[WIDTH-1 -: DIGIT];

   always_comb begin
      decided = gt_s_q | lt_s_q;
      gt_d    = gt_s_q | (!decided && (da > db));
      lt_d    = lt_s_q | (!decided && (da < db));
      last_d  = (idx_q == '0);
`ifdef CMP_EARLY_EXIT_EN
      exit_d  = last_d | (!decided && (da != db));
`else
      exit_d  = last_d;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         idx_q       <= '0;
         gt_s_q      <= 1'b0;
         lt_s_q      <= 1'b0;
         cyc_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         gt_q        <= 1'b0;
         eq_q        <= 1'b0;
         lt_q        <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  // Inverting the MSB maps two's-complement order onto unsigned order.
                  a_q        <= {A[WIDTH-1] ^ signed_mode, A[WIDTH-2:0]};
                  b_q        <= {B[WIDTH-1] ^ signed_mode, B[WIDTH-2:0]};
                  idx_q      <= IW'(NDIG - 1);
                  gt_s_q     <= 1'b0;
                  lt_s_q     <= 1'b0;
                  cyc_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= S_COMPARE;
               end
            end
            S_COMPARE: begin
               gt_s_q <= gt_d;
               lt_s_q <= lt_d;
               cyc_q  <= cyc_q + CW'(1);
               a_q    <= a_q << DIGIT;
               b_q    <= b_q << DIGIT;
               idx_q  <= idx_q - IW'(1);
               if (exit_d) begin
                  state_q     <= S_DONE;
                  out_valid_q <= 1'b1;
                  gt_q        <= gt_d;
                  lt_q        <= lt_d;
                  eq_q        <= !(gt_d | lt_d);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
                  gt_q        <= 1'b0;
                  eq_q        <= 1'b0;
                  lt_q        <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               gt_q        <= 1'b0;
               eq_q        <= 1'b0;
               lt_q        <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign A_greater_B = gt_q;
   assign A_equals_B  = eq_q;
   assign A_less_B    = lt_q;
   assign cycles      = cyc_q;

endmodule
